// File: rtl/arb_link_receiver.sv
// Receiving end of the arbiter channel link: splits the 16-bit word stream into
// trigger pulses, comma-framed data blocks with sof/eof, and error/statistics flags.
module arb_link_receiver #(
  parameter int unsigned MAXLEN   = 1024,
  parameter logic [15:0] CH_COMMA = 16'h00BC,
  parameter logic [15:0] CH_TRIG  = 16'h801C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] din,
  input  logic        kchar,
  output logic        trig,
  output logic [15:0] dout,
  output logic        dvalid,
  output logic        sof,
  output logic        eof,
  output logic        err_kchar,
  output logic        err_long,
  output logic [31:0] trig_cnt,
  output logic [31:0] blk_cnt
);

  localparam logic [15:0] MAXLEN_W = 16'(MAXLEN);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BLOCK   = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic        first_q, first_d;
  logic [15:0] len_q, len_d;

  logic        trig_q, trig_d;
  logic [15:0] dout_q, dout_d;
  logic        dvalid_q, dvalid_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic        err_kchar_q, err_kchar_d;
  logic        err_long_q, err_long_d;
  logic [31:0] trig_cnt_q, trig_cnt_d;
  logic [31:0] blk_cnt_q, blk_cnt_d;

  logic is_trig, is_comma, is_badk, is_data;

  assign is_trig  = kchar && (din == CH_TRIG);
  assign is_comma = kchar && (din == CH_COMMA);
  assign is_badk  = kchar && !is_trig && !is_comma;
  assign is_data  = !kchar;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    first_d     = first_q;
    len_d       = len_q;
    dout_d      = dout_q;
    dvalid_d    = 1'b0;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    err_kchar_d = 1'b0;
    err_long_d  = 1'b0;
    blk_cnt_d   = blk_cnt_q;
    // Triggers are out of band and never touch the block state below.
    trig_d      = is_trig;
    trig_cnt_d  = trig_cnt_q + 32'(is_trig);

    case (state_q)
      S_IDLE: begin
        if (is_data) begin
          hold_d  = din;
          first_d = 1'b1;
          len_d   = 16'd1;
          state_d = S_BLOCK;
        end else if (is_badk) begin
          err_kchar_d = 1'b1;
        end
      end

      S_BLOCK: begin
        if (is_data) begin
          dvalid_d = 1'b1;
          dout_d   = hold_q;
          sof_d    = first_q;
          first_d  = 1'b0;
          if (len_q >= MAXLEN_W) begin
            // Held word closes the truncated block; the incoming word is dropped.
            eof_d      = 1'b1;
            err_long_d = 1'b1;
            blk_cnt_d  = blk_cnt_q + 32'd1;
            state_d    = S_DISCARD;
          end else begin
            hold_d = din;
            len_d  = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
          end
        end else if (is_comma || is_badk) begin
          dvalid_d    = 1'b1;
          dout_d      = hold_q;
          sof_d       = first_q;
          eof_d       = 1'b1;
          first_d     = 1'b0;
          err_kchar_d = is_badk;
          blk_cnt_d   = blk_cnt_q + 32'd1;
          state_d     = S_IDLE;
        end
      end

      S_DISCARD: begin
        if (is_comma) begin
          state_d = S_IDLE;
        end else if (is_badk) begin
          err_kchar_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      first_q     <= 1'b0;
      len_q       <= '0;
      trig_q      <= 1'b0;
      dout_q      <= '0;
      dvalid_q    <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      err_kchar_q <= 1'b0;
      err_long_q  <= 1'b0;
      trig_cnt_q  <= '0;
      blk_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      first_q     <= first_d;
      len_q       <= len_d;
      trig_q      <= trig_d;
      dout_q      <= dout_d;
      dvalid_q    <= dvalid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      err_kchar_q <= err_kchar_d;
      err_long_q  <= err_long_d;
      trig_cnt_q  <= trig_cnt_d;
      blk_cnt_q   <= blk_cnt_d;
    end
  end

  assign trig      = trig_q;
  assign dout      = dout_q;
  assign dvalid    = dvalid_q;
  assign sof       = sof_q;
  assign eof       = eof_q;
  assign err_kchar = err_kchar_q;
  assign err_long  = err_long_q;
  assign trig_cnt  = trig_cnt_q;
  assign blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_arb_link_receiver.sv
// Directed bench for arb_link_receiver: expected block words are queued as they are
// sent and checked as the receiver emits them; pulses and counters checked per step.
module tb_arb_link_receiver;

  localparam logic [15:0] COMMA = 16'h00BC;
  localparam logic [15:0] TRIGW = 16'h801C;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic        kchar;
  logic        trig;
  logic [15:0] dout;
  logic        dvalid;
  logic        sof;
  logic        eof;
  logic        err_kchar;
  logic        err_long;
  logic [31:0] trig_cnt;
  logic [31:0] blk_cnt;

  arb_link_receiver #(
    .MAXLEN  (4),
    .CH_COMMA(COMMA),
    .CH_TRIG (TRIGW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .kchar    (kchar),
    .trig     (trig),
    .dout     (dout),
    .dvalid   (dvalid),
    .sof      (sof),
    .eof      (eof),
    .err_kchar(err_kchar),
    .err_long (err_long),
    .trig_cnt (trig_cnt),
    .blk_cnt  (blk_cnt)
  );

  typedef struct {
    logic [15:0] d;
    logic        s;
    logic        e;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_mis = 0;
  int words_seen = 0;
  int trig_seen = 0;
  int errk_seen = 0;
  int errl_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic k, input logic [15:0] d);
    @(negedge clk);
    kchar = k;
    din   = d;
  endtask

  task automatic data(input logic [15:0] d);
    send(1'b0, d);
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b1, COMMA);
  endtask

  task automatic push(input logic [15:0] d, input logic s, input logic e);
    exp_t x;
    x.d = d;
    x.s = s;
    x.e = e;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (trig) trig_seen++;
      if (err_kchar) errk_seen++;
      if (err_long) errl_seen++;
      if (dvalid) begin
        words_seen++;
        if (sb.size() == 0) begin
          chk("unexpected_word", {31'b0, dvalid}, 32'd0);
        end else begin
          exp_t x;
          x = sb.pop_front();
          chk("word", {14'b0, sof, eof, dout}, {14'b0, x.s, x.e, x.d});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, k0, l0, w0;
    rst_n = 1'b0;
    kchar = 1'b1;
    din   = COMMA;

    // Reset state
    @(negedge clk);
    chk("rst_flags", {25'b0, trig, dvalid, sof, eof, err_kchar, err_long, 1'b0}, 32'd0);
    chk("rst_dout", {16'b0, dout}, 32'd0);
    chk("rst_cnts", trig_cnt | blk_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle stream
    idle(20);
    chk("idle_words", 32'(words_seen), 32'd0);
    chk("idle_pulses", 32'(trig_seen + errk_seen + errl_seen), 32'd0);
    chk("idle_trig_cnt", trig_cnt, 32'd0);
    chk("idle_blk_cnt", blk_cnt, 32'd0);

    // Basic block
    send(1'b1, COMMA);
    push(16'h1111, 1'b1, 1'b0);
    push(16'h2222, 1'b0, 1'b0);
    push(16'h3333, 1'b0, 1'b1);
    data(16'h1111);
    data(16'h2222);
    data(16'h3333);
    send(1'b1, COMMA);
    idle(3);
    chk("basic_drained", 32'(sb.size()), 32'd0);
    chk("basic_words", 32'(words_seen), 32'd3);
    chk("basic_blk_cnt", blk_cnt, 32'd1);

    // Single-word block, then trigger
    push(16'hABCD, 1'b1, 1'b1);
    data(16'hABCD);
    send(1'b1, COMMA);
    send(1'b1, TRIGW);
    send(1'b1, COMMA);
    chk("trig_pulse", {31'b0, trig}, 32'd1);
    chk("trig_cnt_1", trig_cnt, 32'd1);
    send(1'b1, COMMA);
    chk("trig_one_cycle", {31'b0, trig}, 32'd0);
    idle(2);
    chk("single_drained", 32'(sb.size()), 32'd0);
    chk("single_blk_cnt", blk_cnt, 32'd2);

    // Trigger inside a block
    t0 = trig_seen;
    w0 = words_seen;
    push(16'h0001, 1'b1, 1'b0);
    push(16'h0002, 1'b0, 1'b1);
    data(16'h0001);
    send(1'b1, TRIGW);
    data(16'h0002);
    send(1'b1, COMMA);
    idle(3);
    chk("inblk_trig_pulses", 32'(trig_seen - t0), 32'd1);
    chk("inblk_words", 32'(words_seen - w0), 32'd2);
    chk("inblk_drained", 32'(sb.size()), 32'd0);
    chk("inblk_blk_cnt", blk_cnt, 32'd3);
    chk("inblk_trig_cnt", trig_cnt, 32'd2);

    // Overlength block, MAXLEN=4
    l0 = errl_seen;
    w0 = words_seen;
    push(16'd1, 1'b1, 1'b0);
    push(16'd2, 1'b0, 1'b0);
    push(16'd3, 1'b0, 1'b0);
    push(16'd4, 1'b0, 1'b1);
    for (int i = 1; i <= 6; i++) data(16'(i));
    send(1'b1, COMMA);
    idle(3);
    chk("long_err_pulses", 32'(errl_seen - l0), 32'd1);
    chk("long_words", 32'(words_seen - w0), 32'd4);
    chk("long_drained", 32'(sb.size()), 32'd0);
    chk("long_blk_cnt", blk_cnt, 32'd4);

    // Bad K character closes block
    k0 = errk_seen;
    push(16'd7, 1'b1, 1'b0);
    push(16'd8, 1'b0, 1'b1);
    data(16'd7);
    data(16'd8);
    send(1'b1, 16'h80FC);
    send(1'b1, COMMA);
    idle(3);
    chk("badk_err_pulses", 32'(errk_seen - k0), 32'd1);
    chk("badk_drained", 32'(sb.size()), 32'd0);
    chk("badk_blk_cnt", blk_cnt, 32'd5);

    // Mid-block asynchronous reset
    w0 = words_seen;
    data(16'd9);
    data(16'd10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_flags", {25'b0, trig, dvalid, sof, eof, err_kchar, err_long, 1'b0}, 32'd0);
    chk("arst_dout", {16'b0, dout}, 32'd0);
    chk("arst_trig_cnt", trig_cnt, 32'd0);
    chk("arst_blk_cnt", blk_cnt, 32'd0);
    send(1'b1, COMMA);
    send(1'b1, COMMA);
    rst_n = 1'b1;
    idle(3);
    chk("arst_no_eof", 32'(words_seen - w0), 32'd0);
    push(16'h00A0, 1'b1, 1'b0);
    push(16'h00A1, 1'b0, 1'b1);
    data(16'h00A0);
    data(16'h00A1);
    send(1'b1, COMMA);
    idle(3);
    chk("post_rst_words", 32'(words_seen - w0), 32'd2);
    chk("post_rst_drained", 32'(sb.size()), 32'd0);
    chk("post_rst_blk_cnt", blk_cnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/arb_link_receiver.md
Name: arb_link_receiver

Overview:
- Receiving end of the 16-bit channel link driven by the channel arbiter.
- Decodes the link word stream into three things:
  - single-cycle trigger pulses from K28.0;
  - framed data blocks from runs of non-K words, delimited by K28.5 commas;
  - error and statistics indications.
- Sits in the main FPGA between the link deserializer/8b10b decoder and the event-building FIFO.

Parameters:
- MAXLEN, 1024, maximum accepted block length in words; longer blocks are truncated.
- CH_COMMA, 16'h00BC, comma/idle K word (K28.5).
- CH_TRIG, 16'h801C, trigger K word (K28.0).

Ports:
- clk  in  1  link word clock, one word per cycle.
- rst_n  in  1  asynchronous active-low reset.
- din  in  16  decoded link word.
- kchar  in  1  1 = din is a K character.
- trig  out  1  one-cycle pulse per received CH_TRIG.
- dout  out  16  block data word.
- dvalid  out  1  dout valid this cycle. No backpressure: downstream must accept every valid word.
- sof  out  1  with dvalid, marks the first word of a block.
- eof  out  1  with dvalid, marks the last word of a block.
- err_kchar  out  1  one-cycle pulse on an unknown K word.
- err_long  out  1  one-cycle pulse when a block is truncated at MAXLEN.
- trig_cnt  out  32  received trigger count, wraps at 2^32.
- blk_cnt  out  32  count of blocks emitted with eof, wraps at 2^32.

Behaviour:
- Reset (rst_n low, asynchronous): every output is 0; state is IDLE; the hold register is empty.
- Input classes, one per cycle:
  - TRIG: kchar=1 and din=CH_TRIG.
  - COMMA: kchar=1 and din=CH_COMMA.
  - BADK: kchar=1 with any other din.
  - DATA: kchar=0.
- Trigger is out of band:
  - trig is asserted exactly 1 cycle after a TRIG input, in every state.
  - trig_cnt increments in the same cycle.
  - A TRIG never affects block state; a TRIG inside a block is transparent and the block continues.
- End of a block is known only when the next COMMA arrives, so every data word is held one word in a hold register before it is emitted.
- States:
  - IDLE:
    - DATA: load hold, set first=1, len=1, go to BLOCK.
    - COMMA, TRIG, BADK: stay in IDLE; BADK also pulses err_kchar.
  - BLOCK:
    - DATA: emit the held word (dvalid=1, sof=first, eof=0), clear first, load hold with din, len=len+1.
    - COMMA: emit the held word with eof=1 (sof=first, so a 1-word block has sof=eof=1); blk_cnt+1; go to IDLE.
    - TRIG: no emission, hold unchanged.
    - BADK: emit the held word with eof=1, pulse err_kchar, blk_cnt+1, go to IDLE. The block is closed early and marked by the error.
  - Truncation at MAXLEN:
    - Applies in BLOCK when a DATA word arrives with len==MAXLEN.
    - Emit the held word with eof=1, pulse err_long, blk_cnt+1, drop the incoming word, go to DISCARD.
  - DISCARD:
    - DATA: dropped.
    - COMMA: go to IDLE.
    - TRIG: handled as usual.
    - BADK: pulse err_kchar, go to IDLE.
- Output latency: a data word appears on dout exactly 1 cycle after the following link word (DATA or COMMA) is received. Output signals are registered.
- Length counter: 16 bits, saturating. MAXLEN must be ≤ 65535 and ≥ 1.
- Every sof is eventually followed by exactly one eof. At most one word is emitted per cycle.

Test Plan:
- Idle stream:
  - Stimulus: reset, then 20 commas.
  - Required: dvalid, trig and both err signals stay 0; all counters stay 0.
- Basic block:
  - Stimulus: COMMA, DATA 0x1111, 0x2222, 0x3333, COMMA.
  - Required: three dvalid cycles, words 0x1111(sof), 0x2222, 0x3333(eof); blk_cnt=1.
- Single-word block and trigger:
  - Stimulus: DATA 0xABCD, COMMA, then TRIG.
  - Required: one word 0xABCD with sof=eof=1; then trig pulses once and trig_cnt=1.
- Trigger inside a block:
  - Stimulus: DATA 0x0001, TRIG, DATA 0x0002, COMMA.
  - Required: trig pulses once; block 0x0001(sof), 0x0002(eof) with no gap word and no break.
- Overlength block:
  - Stimulus: MAXLEN=4, six DATA words 1..6, then COMMA.
  - Required: words 1..4 are emitted, with 4 carrying eof; err_long pulses once; words 5 and 6 are dropped; blk_cnt=1.
- Bad K-char and mid-block reset:
  - Stimulus: DATA 7, 8, BADK 0x80FC, then COMMA.
  - Required: 7(sof), 8(eof), err_kchar pulses once.
  - Stimulus: DATA 9, then rst_n low in the middle of the next DATA.
  - Required: outputs go to 0 immediately and no eof is emitted; after release, a new block starts cleanly with sof.
